regfile_bypass: RTL

- Architectural register file directly upstream of the ALU in the single-cycle datapath.
- Holds 32 general-purpose 32-bit registers.
- Two combinational read ports supply data_operandA / data_operandB to the ALU.
- One synchronous write port takes the writeback value, normally the ALU data_result.
- Register 0 is hardwired to zero.
- Optional write-to-read bypass lets a read of the register being written return the new value in the same cycle.

---
 rtl/regfile_bypass.sv | 61 ++++++
 1 files changed

// File: rtl/regfile_bypass.sv
// Register file with 32 general-purpose registers, two combinational read ports and one write port.
// r0 always reads zero. With BYPASS=1, a read of the register being written returns the new data.
module regfile_bypass #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_BITS = 5,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                 clock,
    input  logic                 ctrl_reset_n,
    input  logic                 ctrl_writeEnable,
    input  logic [ADDR_BITS-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]     data_writeReg,
    input  logic [ADDR_BITS-1:0] ctrl_readRegA,
    input  logic [ADDR_BITS-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]     data_readRegA,
    output logic [WIDTH-1:0]     data_readRegB
);

    localparam int unsigned NumRegs = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] regs [NumRegs];
    logic             write_hit;

    assign write_hit = ctrl_writeEnable && (ctrl_writeReg != '0);

    // Entry 0 is a constant so that the read mux needs no special case for index 0.
    assign regs[0] = '0;

    for (genvar i = 1; i < NumRegs; i++) begin : g_reg
        logic [WIDTH-1:0] reg_q;

        always_ff @(posedge clock or negedge ctrl_reset_n) begin
            if (!ctrl_reset_n) begin
                reg_q <= '0;
            end else if (write_hit && (ctrl_writeReg == ADDR_BITS'(i))) begin
                reg_q <= data_writeReg;
            end
        end

        assign regs[i] = reg_q;
    end

    logic bypass_a;
    logic bypass_b;

    // The reset term keeps the outputs at zero while reset is held low.
    assign bypass_a = BYPASS && ctrl_reset_n && write_hit && (ctrl_readRegA == ctrl_writeReg);
    assign bypass_b = BYPASS && ctrl_reset_n && write_hit && (ctrl_readRegB == ctrl_writeReg);

    always_comb begin
        data_readRegA = regs[ctrl_readRegA];
        data_readRegB = regs[ctrl_readRegB];
        if (bypass_a) begin
            data_readRegA = data_writeReg;
        end
        if (bypass_b) begin
            data_readRegB = data_writeReg;
        end
    end

endmodule
